// File: rtl/x_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : x_branch_unit
// Brief    : Execute-stage branch/jump resolution with a saturating-counter
//            direction predictor read by fetch and trained by X, plus
//            saturating branch and mispredict statistics.
// Revision : 1.0 - initial release
// ============================================================================
module x_branch_unit #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    // fetch-side prediction lookup
    input  logic [XLEN-1:0] f_pc,
    output logic            f_pred_taken,
    // X-stage instruction
    input  logic            x_valid,
    input  logic [4:0]      x_opcode,
    input  logic [XLEN-1:0] x_pc,
    input  logic [XLEN-1:0] x_imm32,
    input  logic [26:0]     x_target,
    input  logic [XLEN-1:0] x_rd_val,
    input  logic            x_pred_taken,
    input  logic            ne,
    input  logic            lt,
    input  logic            bval,
    input  logic            exc_pending,
    // resolution outputs
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            jal,
    // statistics
    output logic [XLEN-1:0] branch_count,
    output logic [XLEN-1:0] mispredict_count
);

    localparam int IDX_BITS = $clog2(ENTRIES);

    // Control-transfer opcodes
    localparam logic [4:0] C_OP_J   = 5'b00001;
    localparam logic [4:0] C_OP_JAL = 5'b00011;
    localparam logic [4:0] C_OP_JR  = 5'b00100;
    localparam logic [4:0] C_OP_BNE = 5'b00010;
    localparam logic [4:0] C_OP_BLT = 5'b00110;
    localparam logic [4:0] C_OP_BEQ = 5'b11001;
    localparam logic [4:0] C_OP_BBP = 5'b11000;
    localparam logic [4:0] C_OP_BEX = 5'b10110;

    // Counter reset value: weakly not-taken (MSB clear, all lower bits set)
    localparam int                C_CTR_INIT_INT = (1 << (CTR_BITS - 1)) - 1;
    localparam logic [CTR_BITS-1:0] C_CTR_INIT   = C_CTR_INIT_INT[CTR_BITS-1:0];
    localparam logic [CTR_BITS-1:0] C_CTR_MAX    = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] C_CTR_ZERO   = {CTR_BITS{1'b0}};
    localparam logic [XLEN-1:0]     C_ONE        = XLEN'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CTR_BITS-1:0] r_table [ENTRIES];
    logic [XLEN-1:0]     r_branch_count;
    logic [XLEN-1:0]     r_mispredict_count;

    // ------------------------------------------------------------------
    // Decode and resolution wires
    // ------------------------------------------------------------------
    logic                w_is_j;
    logic                w_is_jal;
    logic                w_is_jr;
    logic                w_is_bex;
    logic                w_is_cond;
    logic                w_is_uncond;
    logic                w_taken;
    logic [XLEN-1:0]     w_pc_plus1;
    logic [XLEN-1:0]     w_br_target;
    logic [XLEN-1:0]     w_jump_target;
    logic [XLEN-1:0]     w_uncond_target;
    logic                w_train;
    logic                w_mispredict;
    logic [IDX_BITS-1:0] w_x_idx;
    logic [IDX_BITS-1:0] w_f_idx;
    logic                w_unused_f_pc;

    assign w_is_j      = (x_opcode == C_OP_J);
    assign w_is_jal    = (x_opcode == C_OP_JAL);
    assign w_is_jr     = (x_opcode == C_OP_JR);
    assign w_is_bex    = (x_opcode == C_OP_BEX);
    assign w_is_cond   = (x_opcode == C_OP_BNE) || (x_opcode == C_OP_BLT) ||
                         (x_opcode == C_OP_BEQ) || (x_opcode == C_OP_BBP);
    assign w_is_uncond = w_is_j || w_is_jal || w_is_jr || w_is_bex;

    assign w_pc_plus1      = x_pc + C_ONE;
    assign w_br_target     = x_pc + x_imm32 + C_ONE;
    assign w_jump_target   = {{(XLEN-27){1'b0}}, x_target};
    assign w_uncond_target = w_is_jr ? x_rd_val : w_jump_target;

    assign w_x_idx = x_pc[IDX_BITS-1:0];
    assign w_f_idx = f_pc[IDX_BITS-1:0];

    // Upper fetch-PC bits do not participate in the table index
    assign w_unused_f_pc = ^f_pc[XLEN-1:IDX_BITS];

    // Only real conditional branches train the table and count statistics
    assign w_train      = x_valid && w_is_cond;
    assign w_mispredict = w_train && (w_taken != x_pred_taken);

    // Branch direction from ALU flags and side inputs
    always_comb begin
        w_taken = 1'b0;
        case (x_opcode)
            C_OP_J, C_OP_JAL, C_OP_JR: w_taken = 1'b1;
            C_OP_BNE:                  w_taken = ne;
            C_OP_BLT:                  w_taken = ~lt & ne;
            C_OP_BEQ:                  w_taken = ~ne;
            C_OP_BBP:                  w_taken = bval;
            C_OP_BEX:                  w_taken = exc_pending;
            default:                   w_taken = 1'b0;
        endcase
    end

    // Redirect decision: conditionals compare against the fetch prediction,
    // unconditionals (never predicted by fetch) redirect whenever taken
    always_comb begin
        redirect    = 1'b0;
        redirect_pc = '0;
        if (x_valid) begin
            if (w_is_cond) begin
                redirect    = (w_taken != x_pred_taken);
                redirect_pc = w_taken ? w_br_target : w_pc_plus1;
            end else if (w_is_uncond && w_taken) begin
                redirect    = 1'b1;
                redirect_pc = w_uncond_target;
            end
        end
    end

    assign jal = x_valid && w_is_jal;

    // Combinational table read; a same-cycle update is not bypassed
    assign f_pred_taken = r_table[w_f_idx][CTR_BITS-1];

    // Predictor table: saturating up/down counter at the X-stage index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= C_CTR_INIT;
            end
        end else if (w_train) begin
            if (w_taken) begin
                if (r_table[w_x_idx] != C_CTR_MAX) begin
                    r_table[w_x_idx] <= r_table[w_x_idx] + 1'b1;
                end
            end else begin
                if (r_table[w_x_idx] != C_CTR_ZERO) begin
                    r_table[w_x_idx] <= r_table[w_x_idx] - 1'b1;
                end
            end
        end
    end

    // Saturating statistics for resolved conditional branches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (w_train && !(&r_branch_count)) begin
                r_branch_count <= r_branch_count + C_ONE;
            end
            if (w_mispredict && !(&r_mispredict_count)) begin
                r_mispredict_count <= r_mispredict_count + C_ONE;
            end
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule
`default_nettype wire

// File: tb/tb_x_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_x_branch_unit
// Brief    : Scoreboard bench for x_branch_unit with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_x_branch_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [XLEN-1:0] f_pc = '0;
    logic            f_pred_taken;
    logic            x_valid = 1'b0;
    logic [4:0]      x_opcode = '0;
    logic [XLEN-1:0] x_pc = '0;
    logic [XLEN-1:0] x_imm32 = '0;
    logic [26:0]     x_target = '0;
    logic [XLEN-1:0] x_rd_val = '0;
    logic            x_pred_taken = 1'b0;
    logic            ne = 1'b0;
    logic            lt = 1'b0;
    logic            bval = 1'b0;
    logic            exc_pending = 1'b0;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            jal;
    logic [XLEN-1:0] branch_count;
    logic [XLEN-1:0] mispredict_count;

    x_branch_unit #(.XLEN(32), .ENTRIES(16), .CTR_BITS(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .f_pc             (f_pc),
        .f_pred_taken     (f_pred_taken),
        .x_valid          (x_valid),
        .x_opcode         (x_opcode),
        .x_pc             (x_pc),
        .x_imm32          (x_imm32),
        .x_target         (x_target),
        .x_rd_val         (x_rd_val),
        .x_pred_taken     (x_pred_taken),
        .ne               (ne),
        .lt               (lt),
        .bval             (bval),
        .exc_pending      (exc_pending),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .jal              (jal),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        redir;
        logic [31:0] rpc;
        logic        chk_rpc;
        logic        jal;
        logic        fpred;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;

    // reference predictor state
    int          m_ctr[16];
    logic [31:0] m_bc;
    logic [31:0] m_mc;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_ctr[i] = 1;
        m_bc = '0;
        m_mc = '0;
    endtask

    task automatic chk(input string name, input int id, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got 0x%0h expected 0x%0h", name, id, act, exp);
        end
    endtask

    // Drive one X/F cycle; push the hand-computed response; advance the model.
    // upd: 0 = no training, 1 = counter up, 2 = counter down
    task automatic issue(input int id, input logic v, input logic [4:0] op,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [26:0] tgt, input logic [31:0] rdv,
                         input logic pred, input logic f_ne, input logic f_lt,
                         input logic bv, input logic exc, input logic [31:0] fpc,
                         input logic e_redir, input logic [31:0] e_rpc,
                         input logic e_chk_rpc, input logic e_jal, input int upd);
        exp_t e;
        int   idx;
        @(posedge clk);
        #1;
        x_valid = v; x_opcode = op; x_pc = pc; x_imm32 = imm; x_target = tgt;
        x_rd_val = rdv; x_pred_taken = pred; ne = f_ne; lt = f_lt; bval = bv;
        exc_pending = exc; f_pc = fpc;
        e.id = id; e.redir = e_redir; e.rpc = e_rpc; e.chk_rpc = e_chk_rpc;
        e.jal = e_jal; e.fpred = (m_ctr[fpc[3:0]] >= 2); e.bc = m_bc; e.mc = m_mc;
        sb_q.push_back(e);
        idx = int'(pc[3:0]);
        if (upd != 0) begin
            if (upd == 1 && m_ctr[idx] < 3) m_ctr[idx]++;
            if (upd == 2 && m_ctr[idx] > 0) m_ctr[idx]--;
            if (m_bc != 32'hFFFF_FFFF) m_bc++;
            if (e_redir && m_mc != 32'hFFFF_FFFF) m_mc++;
        end
    endtask

    task automatic idle(input int id, input logic [31:0] fpc);
        issue(id, 1'b0, 5'b00010, 32'd0, 32'd0, 27'd0, 32'd0, 1'b0, 1'b1, 1'b0,
              1'b0, 1'b0, fpc, 1'b0, 32'd0, 1'b1, 1'b0, 0);
    endtask

    // Monitor: compare whatever the DUT presents mid-cycle against the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("redirect", e.id, 64'(redirect), 64'(e.redir));
                if (e.chk_rpc) chk("redirect_pc", e.id, 64'(redirect_pc), 64'(e.rpc));
                chk("jal", e.id, 64'(jal), 64'(e.jal));
                chk("f_pred_taken", e.id, 64'(f_pred_taken), 64'(e.fpred));
                chk("branch_count", e.id, 64'(branch_count), 64'(e.bc));
                chk("mispredict_count", e.id, 64'(mispredict_count), 64'(e.mc));
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sb_q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (sb_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d entries pending, expected 0", sb_q.size());
        end
    endtask

    localparam logic [4:0] OP_J = 5'b00001, OP_JAL = 5'b00011, OP_JR = 5'b00100,
                           OP_BNE = 5'b00010, OP_BLT = 5'b00110, OP_BEQ = 5'b11001,
                           OP_BBP = 5'b11000, OP_BEX = 5'b10110;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // reset state
        idle(0, 32'd5);
        // bne training at pc 3 (imm 10 -> target 14), fetch keeps predicting 0
        issue(1, 1, OP_BNE, 32'd3, 32'd10, 27'd0, 32'd0, 0, 1, 0, 0, 0, 32'd3, 1, 32'd14, 1, 0, 1);
        issue(2, 1, OP_BNE, 32'd3, 32'd10, 27'd0, 32'd0, 0, 1, 0, 0, 0, 32'd3, 1, 32'd14, 1, 0, 1);
        issue(3, 1, OP_BNE, 32'd3, 32'd10, 27'd0, 32'd0, 0, 1, 0, 0, 0, 32'd3, 1, 32'd14, 1, 0, 1);
        idle(4, 32'd3);
        // blt predicted taken, lt=1 -> not taken, fall through to 8
        issue(5, 1, OP_BLT, 32'd7, 32'd5, 27'd0, 32'd0, 1, 1, 1, 0, 0, 32'd7, 1, 32'd8, 1, 0, 2);
        // blt predicted taken and taken -> no redirect, pc 13
        issue(6, 1, OP_BLT, 32'd7, 32'd5, 27'd0, 32'd0, 1, 1, 0, 0, 0, 32'd7, 0, 32'd13, 1, 0, 1);
        // jr to 0x40
        issue(7, 1, OP_JR, 32'd20, 32'd0, 27'd0, 32'h40, 0, 0, 0, 0, 0, 32'd3, 1, 32'h40, 1, 0, 0);
        // jal to 0x123
        issue(8, 1, OP_JAL, 32'd30, 32'd0, 27'h123, 32'd0, 0, 0, 0, 0, 0, 32'd3, 1, 32'h123, 1, 1, 0);
        // bex not taken / taken (prediction ignored)
        issue(9, 1, OP_BEX, 32'd31, 32'd0, 27'h55, 32'd0, 0, 0, 0, 0, 0, 32'd3, 0, 32'd0, 0, 0, 0);
        issue(10, 1, OP_BEX, 32'd31, 32'd0, 27'h55, 32'd0, 1, 0, 0, 0, 1, 32'd3, 1, 32'h55, 1, 0, 0);
        // j to 0x7FFFFFF (widest target)
        issue(11, 1, OP_J, 32'd32, 32'd0, 27'h7FF_FFFF, 32'd0, 0, 0, 0, 0, 0, 32'd3, 1, 32'h07FF_FFFF, 1, 0, 0);
        // bubble beq, ne=0: nothing happens
        issue(12, 0, OP_BEQ, 32'd3, 32'd10, 27'd0, 32'd0, 0, 0, 0, 0, 0, 32'd3, 0, 32'd0, 1, 0, 0);
        // beq taken as predicted
        issue(13, 1, OP_BEQ, 32'd3, 32'd10, 27'd0, 32'd0, 1, 0, 0, 0, 0, 32'd3, 0, 32'd14, 1, 0, 1);
        // collision: bbp at 0x17 (index 7, aliased) with f_pc index 7
        issue(14, 1, OP_BBP, 32'h17, 32'd5, 27'd0, 32'd0, 0, 0, 0, 1, 0, 32'd7, 1, 32'h1D, 1, 0, 1);
        idle(15, 32'd7);
        // negative immediate, not-taken bne, pc 100 (index 4)
        issue(16, 1, OP_BNE, 32'd100, 32'hFFFF_FFFC, 27'd0, 32'd0, 0, 0, 0, 0, 0, 32'd4, 0, 32'd101, 1, 0, 2);
        // non-control opcode
        issue(17, 1, 5'b00000, 32'd50, 32'd0, 27'd0, 32'd0, 1, 1, 0, 1, 1, 32'd4, 0, 32'd0, 1, 0, 0);
        // pc wrap on fall-through
        issue(18, 1, OP_BNE, 32'hFFFF_FFFF, 32'd0, 27'd0, 32'd0, 1, 0, 0, 0, 0, 32'd4, 1, 32'd0, 1, 0, 2);
        idle(19, 32'd15);
        drain();

        // mispredict counter saturation
        @(posedge clk);
        #1 force dut.r_mispredict_count = 32'hFFFF_FFFF;
        #1 release dut.r_mispredict_count;
        m_mc = 32'hFFFF_FFFF;
        issue(20, 1, OP_BNE, 32'd9, 32'd1, 27'd0, 32'd0, 0, 1, 0, 0, 0, 32'd9, 1, 32'd11, 1, 0, 1);
        idle(21, 32'd9);
        drain();

        // asynchronous reset between edges
        @(posedge clk);
        #1 f_pc = 32'd3;
        #1 chk("pre_reset_pred", 22, 64'(f_pred_taken), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_pred", 23, 64'(f_pred_taken), 64'd0);
        chk("reset_bc", 23, 64'(branch_count), 64'd0);
        chk("reset_mc", 23, 64'(mispredict_count), 64'd0);
        // training pending across an edge under reset is discarded
        x_valid = 1'b1; x_opcode = OP_BNE; x_pc = 32'd3; ne = 1'b1; x_pred_taken = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        x_valid = 1'b0;
        model_reset();
        idle(24, 32'd3);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded 20000 time units, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
